// File: rtl/dma_cnt_pkg.sv
// Shared types and defaults for the DMA word counter.
package dma_cnt_pkg;

    typedef enum logic [1:0] {
        CM_WRAP   = 2'd0,
        CM_HOLD   = 2'd1,
        CM_RELOAD = 2'd2,
        CM_RSVD   = 2'd3
    } cnt_mode_e;

    localparam int CNT_WIDTH_DEF = 8;

endpackage

// File: rtl/dma_word_counter.sv
// WIDTH-bit up/down DMA word counter with parallel load, reload register,
// selectable terminal behaviour, sticky terminal-count flag and active-low carry chain.
module dma_word_counter
    import dma_cnt_pkg::*;
#(
    parameter int               WIDTH      = CNT_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RELOAD_RST = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pl,
    input  logic [WIDTH-1:0] di,
    input  logic             enc,
    input  logic             inc,
    input  logic             dec,
    input  logic             cin,
    input  logic [1:0]       mode,
    input  logic             tc_clr,
    output logic [WIDTH-1:0] dataout,
    output logic [WIDTH-1:0] reload_q,
    output logic             co,
    output logic             tc,
    output logic             tc_pulse
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_d;
    logic             tc_q, tc_d;
    logic             pulse_q, pulse_d;

    cnt_mode_e mode_e;
    logic      at_max, at_min;
    logic      up, step, term;

    assign mode_e = cnt_mode_e'(mode);
    assign at_max = (count_q == ALL_ONES);
    assign at_min = (count_q == ZERO);
    assign up     = inc;
    assign step   = enc & ~cin & (inc | dec);
    assign term   = step & ((up & at_max) | (~up & at_min));

    // Carry chain looks only at raw inc/dec, never at mode.
    assign co = (~(at_max & inc & enc) & ~(at_min & dec & enc)) | cin;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        pulse_d  = 1'b0;
        tc_d     = tc_q & ~tc_clr;
        if (pl) begin
            count_d  = di;
            reload_d = di;
        end else begin
            if (step) begin
                if (!term) begin
                    count_d = up ? (count_q + ONE) : (count_q - ONE);
                end else begin
                    case (mode_e)
                        CM_HOLD:   count_d = count_q;
                        CM_RELOAD: count_d = reload_q;
                        default:   count_d = up ? ZERO : ALL_ONES;
                    endcase
                end
            end
            pulse_d = term;
            // A terminal event beats a simultaneous clear.
            tc_d    = term | (tc_q & ~tc_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= ZERO;
            reload_q <= RELOAD_RST;
            tc_q     <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            pulse_q  <= pulse_d;
        end
    end

    assign dataout  = count_q;
    assign tc       = tc_q;
    assign tc_pulse = pulse_q;

endmodule

// File: tb/tb_dma_word_counter.sv
// Randomised and directed checks of dma_word_counter against an arithmetic reference model,
// plus a two-stage cascade.
module tb_dma_word_counter;

    logic       clk = 1'b0;
    logic       reset, pl, enc, inc, dec, cin, tc_clr;
    logic [7:0] di;
    logic [1:0] mode;
    logic [7:0] dataout, reload_q;
    logic       co, tc, tc_pulse;

    logic       c_reset, c_pl, c_enc;
    logic [7:0] lo_di, hi_di;
    logic [7:0] lo_dataout, lo_reload, hi_dataout, hi_reload;
    logic       lo_co, lo_tc, lo_pulse, hi_co, hi_tc, hi_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int m_cnt, m_rel;
    bit m_tc, m_pulse;
    int c_val;

    always #5 clk = ~clk;

    dma_word_counter #(.WIDTH(8), .RELOAD_RST(8'h00)) dut (
        .clk(clk), .reset(reset), .pl(pl), .di(di), .enc(enc), .inc(inc), .dec(dec),
        .cin(cin), .mode(mode), .tc_clr(tc_clr), .dataout(dataout), .reload_q(reload_q),
        .co(co), .tc(tc), .tc_pulse(tc_pulse)
    );

    dma_word_counter #(.WIDTH(8)) u_lo (
        .clk(clk), .reset(c_reset), .pl(c_pl), .di(lo_di), .enc(c_enc), .inc(1'b1), .dec(1'b0),
        .cin(1'b0), .mode(2'd0), .tc_clr(1'b0), .dataout(lo_dataout), .reload_q(lo_reload),
        .co(lo_co), .tc(lo_tc), .tc_pulse(lo_pulse)
    );

    dma_word_counter #(.WIDTH(8)) u_hi (
        .clk(clk), .reset(c_reset), .pl(c_pl), .di(hi_di), .enc(c_enc), .inc(1'b1), .dec(1'b0),
        .cin(lo_co), .mode(2'd0), .tc_clr(1'b0), .dataout(hi_dataout), .reload_q(hi_reload),
        .co(hi_co), .tc(hi_tc), .tc_pulse(hi_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit model_co();
        if (cin) return 1'b1;
        if (enc && ((inc && m_cnt == 255) || (dec && m_cnt == 0))) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: count as an unbounded integer; leaving 0..255 is the terminal event.
    task automatic model_step();
        bit stp, trm;
        int nxt;
        trm = 1'b0;
        if (reset) begin
            m_cnt = 0; m_rel = 0; m_tc = 1'b0; m_pulse = 1'b0;
        end else begin
            if (pl) begin
                m_cnt = int'(di);
                m_rel = int'(di);
            end else begin
                stp = enc && !cin && (inc || dec);
                nxt = m_cnt + (inc ? 1 : -1);
                trm = stp && (nxt < 0 || nxt > 255);
                if (stp) begin
                    if (!trm)           m_cnt = nxt;
                    else if (mode == 1) m_cnt = m_cnt;
                    else if (mode == 2) m_cnt = m_rel;
                    else                m_cnt = (nxt + 256) % 256;
                end
            end
            m_tc    = trm || (m_tc && !tc_clr);
            m_pulse = trm;
        end
        if (c_reset)   c_val = 0;
        else if (c_pl) c_val = {hi_di, lo_di};
        else if (c_enc) c_val = (c_val + 1) % 65536;
    endtask

    task automatic cycle();
        #1;
        check("co", {31'd0, co}, {31'd0, model_co()});
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("dataout", {24'd0, dataout}, m_cnt);
        check("reload_q", {24'd0, reload_q}, m_rel);
        check("tc", {31'd0, tc}, {31'd0, m_tc});
        check("tc_pulse", {31'd0, tc_pulse}, {31'd0, m_pulse});
        $display("cyc %0d rst=%0b pl=%0b di=%02h enc=%0b inc=%0b dec=%0b cin=%0b mode=%0d clr=%0b -> cnt=%02h rel=%02h tc=%0b pulse=%0b co=%0b",
                 cyc, reset, pl, di, enc, inc, dec, cin, mode, tc_clr,
                 dataout, reload_q, tc, tc_pulse, co);
    endtask

    task automatic set_idle();
        reset = 0; pl = 0; di = 8'h00; enc = 0; inc = 0; dec = 0; cin = 0; mode = 2'd0; tc_clr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_seq[4];
        int pulses;

        set_idle();
        c_reset = 1; c_pl = 0; c_enc = 0; lo_di = 8'h00; hi_di = 8'h00;
        m_cnt = 0; m_rel = 0; m_tc = 0; m_pulse = 0; c_val = 0;

        // 1: reset dominates a simultaneous load
        reset = 1; pl = 1; di = 8'h55; enc = 1; inc = 1;
        cycle();
        set_idle();
        #1;
        check("t1_dataout", {24'd0, dataout}, 32'h00);
        check("t1_reload", {24'd0, reload_q}, 32'h00);
        check("t1_tc", {31'd0, tc}, 32'd0);
        check("t1_pulse", {31'd0, tc_pulse}, 32'd0);
        check("t1_co", {31'd0, co}, 32'd1);

        // 2: wrap upward through FF
        pl = 1; di = 8'hFE;
        cycle();
        check("t2_load", {24'd0, dataout}, 32'hFE);
        pl = 0; enc = 1; inc = 1; mode = 2'd0;
        exp_seq = '{8'hFF, 8'h00, 8'h01, 8'h00};
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t2_cnt", {24'd0, dataout}, {24'd0, exp_seq[k]});
            check("t2_pulse", {31'd0, tc_pulse}, (k == 1) ? 32'd1 : 32'd0);
            if (k == 0) begin
                #1;
                check("t2_co_ff", {31'd0, co}, 32'd0);
            end
        end
        check("t2_tc", {31'd0, tc}, 32'd1);

        // 3: hold at zero counting down
        set_idle();
        pl = 1; di = 8'h02; mode = 2'd1;
        cycle();
        pl = 0; enc = 1; dec = 1;
        exp_seq = '{8'h01, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t3_cnt", {24'd0, dataout}, {24'd0, exp_seq[k]});
            check("t3_pulse", {31'd0, tc_pulse}, (k >= 2) ? 32'd1 : 32'd0);
        end
        check("t3_tc", {31'd0, tc}, 32'd1);

        // 4: auto-reload on underflow
        set_idle();
        pl = 1; di = 8'h10; mode = 2'd2;
        cycle();
        pl = 0; enc = 1; dec = 1;
        pulses = 0;
        for (int k = 0; k < 18; k++) begin
            cycle();
            if (tc_pulse) pulses++;
            check("t4_cnt", {24'd0, dataout}, (k < 16) ? 32'h0F - k : ((k == 16) ? 32'h10 : 32'h0F));
        end
        check("t4_pulses", pulses, 32'd1);

        // 5: cin blocks counting, inc beats dec, set beats clear
        set_idle();
        pl = 1; di = 8'h33;
        cycle();
        pl = 0; enc = 1; inc = 1; cin = 1;
        #1;
        check("t5_co_cin", {31'd0, co}, 32'd1);
        cycle();
        check("t5_hold", {24'd0, dataout}, 32'h33);
        cin = 0; dec = 1;
        cycle();
        check("t5_incdec", {24'd0, dataout}, 32'h34);
        set_idle();
        tc_clr = 1;
        cycle();
        check("t5_clr", {31'd0, tc}, 32'd0);
        tc_clr = 0; pl = 1; di = 8'hFF;
        cycle();
        pl = 0; enc = 1; inc = 1; tc_clr = 1;
        cycle();
        check("t5_setwins", {31'd0, tc}, 32'd1);
        check("t5_wrap", {24'd0, dataout}, 32'h00);

        // 6: two cascaded stages 0x00FE -> 0x0102, then reset mid-count
        set_idle();
        c_reset = 0; c_pl = 1; lo_di = 8'hFE; hi_di = 8'h00;
        cycle();
        check("t6_load", {16'd0, hi_dataout, lo_dataout}, c_val);
        c_pl = 0; c_enc = 1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t6_cascade", {16'd0, hi_dataout, lo_dataout}, c_val);
        end
        check("t6_final", {16'd0, hi_dataout, lo_dataout}, 32'h0102);
        c_reset = 1;
        cycle();
        check("t6_reset", {16'd0, hi_dataout, lo_dataout}, 32'h0000);
        c_reset = 0; c_enc = 0;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 39) == 0);
            pl     = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 4))
                0:       di = 8'h00;
                1:       di = 8'h01;
                2:       di = 8'hFE;
                3:       di = 8'hFF;
                default: di = 8'($urandom_range(0, 255));
            endcase
            enc    = ($urandom_range(0, 3) != 0);
            inc    = 1'($urandom_range(0, 1));
            dec    = 1'($urandom_range(0, 1));
            cin    = ($urandom_range(0, 4) == 0);
            mode   = 2'($urandom_range(0, 3));
            tc_clr = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
